dp_sequencer: RTL and testbench
===============================

# dp_sequencer

Finite-state controller that runs a short program through the complex-arithmetic data path. It steps the instruction address, loads the 5-bit instruction register and the two 8-bit operand registers, and lets the ALU settle for one cycle. It then writes the 16-bit result to the upper half of the instruction/result memory. It sits between the host (go/done, operand stream) and the data path's pc, register and memory enables, and replaces the free-running pc with an explicitly sequenced one.

## Interface
- PROG_MAX, 8: maximum instruction count; instruction slots are memory addresses 0..PROG_MAX-1.
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- go  input  1  start program; sampled only in IDLE.
- n_instr  input  4  instruction count for this run, latched on accepted go; values above PROG_MAX are clamped to PROG_MAX.
- inst  input  5  current memory read data (combinational read of r_addr); [4:2] = destination slot, [1:0] = ALU op.
- opnd_valid  input  1  host presents in1/in2 for the current instruction.
- opnd_ready  output  1  operand handshake accept.
- r_addr  output  4  instruction read address.
- ir_load  output  1  load enable, instruction register.
- a_load, b_load  output  1  load enables, operand registers (always equal).
- alu_op  output  2  op of the instruction in flight (from the internal instruction copy).
- mem_we  output  1  result write enable.
- w_addr  output  4  result address = {1'b1, dest[2:0]}.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse at program end.
- wr_count  output  4  results written in the current/last run.

## Operation
- States: IDLE, FETCH, OPND, EXEC, WRITE, FIN.
- IDLE: all strobes 0. When go=1: latch clamped n_instr, clear pc and wr_count. If the count is 0, go to FIN; otherwise go to FETCH.
- FETCH: r_addr=pc, ir_load=1, inst captured into an internal 5-bit copy. Next state is OPND.
- OPND: opnd_ready=1. When opnd_valid=1, a_load=b_load=1 in that same cycle and the next state is EXEC. Otherwise stay in OPND; the stall is unbounded.
- EXEC: no strobes; one cycle for the ALU to settle on the new a/b. Next state is WRITE.
- WRITE: mem_we=1, w_addr={1,copy[4:2]}, wr_count+1. If pc == count-1, go to FIN. Otherwise pc+1 and go to FETCH.
- FIN: done=1 for exactly one cycle, then IDLE.
- go is ignored outside IDLE. A go arriving in the FIN cycle is not accepted.
- r_addr holds pc in every state; pc is 3 bits internally, zero-extended, and never exceeds PROG_MAX-1.
- alu_op and w_addr come from the internal copy, not from the live inst.
- Two instructions with the same dest: the later one overwrites the earlier, and wr_count still counts both.
- wr_count and the latched count hold their values in IDLE until the next accepted go.

## Timing
- Reset values: state=IDLE, pc=0, r_addr=0, every strobe 0, busy=0, done=0, wr_count=0, alu_op=0, w_addr=4'b1000.
- Reset wins over every other input. Reset mid-run aborts on the next edge and no further mem_we is issued.
- Per instruction: FETCH, OPND (≥1 cycle), EXEC, WRITE, which is a minimum of 4 cycles.
- With opnd_valid held high, n instructions take 4n cycles from the go-accepting edge to the FIN state, and done is asserted on cycle 4n+1.
- busy rises the cycle after go is accepted and falls with the FIN→IDLE transition. busy is also high during FIN.
- All outputs are registered or decoded from registered state. There are no combinational paths from go or opnd_valid to any output except opnd_ready-qualified a_load/b_load.

## Test plan
- Reset, then n_instr=3, go=1, opnd_valid held at 1, memory holding 5'b00100 / 5'b01001 / 5'b11111. Required: mem_we pulses at cycles 4, 8 and 12 with w_addr 9, 10, 15 and alu_op 0, 1, 3; done at cycle 13; wr_count=3.
- Operand stall: same program with opnd_valid low for 5 cycles in the first OPND. Required: opnd_ready high throughout the stall, no a_load until valid, first mem_we delayed by exactly 5 cycles.
- n_instr=0 with go. Required: FIN one cycle later, done pulse, no ir_load, no mem_we, wr_count=0. With n_instr=12, exactly 8 writes occur and r_addr never exceeds 7.
- go pulsed while busy and during FIN. Required: ignored, with no restart and no change to the latched count.
- rst asserted during OPND of the second instruction. Required: the next cycle shows IDLE, all outputs at reset values, and no further mem_we. A new go runs normally from pc=0.
- Duplicate destination (two instructions, both dest=2). Required: two writes to address 10 and wr_count=2.

Source files
------------

// File: rtl/dp_sequencer.sv
// dp_sequencer: finite-state controller that steps a short program through the
// complex-arithmetic data path. Each instruction is fetched, its operands are loaded
// through a valid/ready handshake, the ALU is given one settle cycle, and the 16-bit
// result is written to the upper half of the instruction/result memory.
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   go          start program, sampled only in IDLE
//   n_instr     instruction count for the run, clamped to PROG_MAX
//   inst        memory read data for r_addr: [4:2] destination slot, [1:0] ALU op
//   opnd_valid  host presents operands for the current instruction
//   opnd_ready  operand handshake accept
//   r_addr      instruction read address (zero-extended pc)
//   ir_load     instruction register load enable
//   a_load      operand A load enable
//   b_load      operand B load enable (always equal to a_load)
//   alu_op      op of the instruction in flight
//   mem_we      result write enable
//   w_addr      result address {1'b1, dest}
//   busy        high in every state except IDLE
//   done        one-cycle pulse at program end
//   wr_count    results written in the current/last run
module dp_sequencer #(
   parameter int unsigned PROG_MAX = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       go,
   input  logic [3:0] n_instr,
   input  logic [4:0] inst,
   input  logic       opnd_valid,
   output logic       opnd_ready,
   output logic [3:0] r_addr,
   output logic       ir_load,
   output logic       a_load,
   output logic       b_load,
   output logic [1:0] alu_op,
   output logic       mem_we,
   output logic [3:0] w_addr,
   output logic       busy,
   output logic       done,
   output logic [3:0] wr_count
);

   localparam logic [3:0] ProgMax = 4'(PROG_MAX);

   typedef enum logic [2:0] {
      StIdle,
      StFetch,
      StOpnd,
      StExec,
      StWrite,
      StFin
   } state_e;

   state_e     state;
   logic [2:0] pc;
   logic [3:0] count;
   logic [4:0] inst_copy;
   logic [3:0] n_clamped;
   logic       last_instr;

   assign n_clamped  = (n_instr > ProgMax) ? ProgMax : n_instr;
   // count is never 0 outside IDLE/FIN, so count-1 cannot wrap where it is used
   assign last_instr = ({1'b0, pc} == (count - 4'd1));

   assign r_addr = {1'b0, pc};
   assign alu_op = inst_copy[1:0];
   assign w_addr = {1'b1, inst_copy[4:2]};
   // Only combinational path from an input: the operand handshake itself
   assign a_load = opnd_ready & opnd_valid;
   assign b_load = opnd_ready & opnd_valid;

   // Strobes are registered: each is set on the edge that enters the state it belongs to.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= StIdle;
         pc         <= 3'd0;
         count      <= 4'd0;
         inst_copy  <= 5'd0;
         wr_count   <= 4'd0;
         ir_load    <= 1'b0;
         opnd_ready <= 1'b0;
         mem_we     <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         ir_load    <= 1'b0;
         opnd_ready <= 1'b0;
         mem_we     <= 1'b0;
         done       <= 1'b0;
         unique case (state)
            StIdle: begin
               if (go) begin
                  count    <= n_clamped;
                  pc       <= 3'd0;
                  wr_count <= 4'd0;
                  busy     <= 1'b1;
                  if (n_clamped == 4'd0) begin
                     state <= StFin;
                     done  <= 1'b1;
                  end else begin
                     state   <= StFetch;
                     ir_load <= 1'b1;
                  end
               end
            end
            StFetch: begin
               inst_copy  <= inst;
               state      <= StOpnd;
               opnd_ready <= 1'b1;
            end
            StOpnd: begin
               if (opnd_valid) begin
                  state <= StExec;
               end else begin
                  opnd_ready <= 1'b1;
               end
            end
            StExec: begin
               state  <= StWrite;
               mem_we <= 1'b1;
            end
            StWrite: begin
               wr_count <= wr_count + 4'd1;
               if (last_instr) begin
                  state <= StFin;
                  done  <= 1'b1;
               end else begin
                  pc      <= pc + 3'd1;
                  state   <= StFetch;
                  ir_load <= 1'b1;
               end
            end
            StFin: begin
               state <= StIdle;
               busy  <= 1'b0;
            end
            default: begin
               state <= StIdle;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dp_sequencer.sv
// tb_dp_sequencer: directed self-checking bench for dp_sequencer. Cycle 0 is the IDLE
// cycle in which go is presented; the go-accepting edge ends cycle 0. Inputs are driven
// just after the falling edge and outputs are observed 1 ns later.
module tb_dp_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic       go;
   logic [3:0] n_instr;
   logic [4:0] inst;
   logic       opnd_valid;
   logic       opnd_ready;
   logic [3:0] r_addr;
   logic       ir_load;
   logic       a_load;
   logic       b_load;
   logic [1:0] alu_op;
   logic       mem_we;
   logic [3:0] w_addr;
   logic       busy;
   logic       done;
   logic [3:0] wr_count;

   logic [4:0] mem [16];
   int         n_checks = 0;
   int         n_fail = 0;

   always #5 clk = ~clk;
   assign inst = mem[r_addr];

   dp_sequencer #(.PROG_MAX(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .go         (go),
      .n_instr    (n_instr),
      .inst       (inst),
      .opnd_valid (opnd_valid),
      .opnd_ready (opnd_ready),
      .r_addr     (r_addr),
      .ir_load    (ir_load),
      .a_load     (a_load),
      .b_load     (b_load),
      .alu_op     (alu_op),
      .mem_we     (mem_we),
      .w_addr     (w_addr),
      .busy       (busy),
      .done       (done),
      .wr_count   (wr_count)
   );

   task automatic load_basic_program();
      for (int i = 0; i < 16; i++) mem[i] = 5'b00000;
      mem[0] = 5'b00100;
      mem[1] = 5'b01001;
      mem[2] = 5'b11111;
   endtask

   task automatic test_reset();
      rst = 1'b1; go = 1'b1; opnd_valid = 1'b1; n_instr = 4'd3;
      repeat (3) @(negedge clk);
      #1;
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
      n_checks++; if (r_addr !== 4'd0) begin n_fail++; $display("FAIL rst_r_addr: got %0d want 0", r_addr); end
      n_checks++;
      if ({ir_load, a_load, b_load, opnd_ready, mem_we, done} !== 6'b0) begin
         n_fail++;
         $display("FAIL rst_strobes: got %b want 000000",
                  {ir_load, a_load, b_load, opnd_ready, mem_we, done});
      end
      n_checks++; if (wr_count !== 4'd0) begin n_fail++; $display("FAIL rst_wr_count: got %0d want 0", wr_count); end
      n_checks++; if (alu_op !== 2'd0) begin n_fail++; $display("FAIL rst_alu_op: got %0d want 0", alu_op); end
      n_checks++; if (w_addr !== 4'd8) begin n_fail++; $display("FAIL rst_w_addr: got %0d want 8", w_addr); end
      rst = 1'b0; go = 1'b0;
      @(negedge clk); #1;
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_go_held: busy got %b want 0", busy); end
   endtask

   task automatic test_basic_program();
      int exp_cyc[3] = '{4, 8, 12};
      int exp_wa[3]  = '{9, 10, 15};
      int exp_op[3]  = '{0, 1, 3};
      int wi = 0;
      int done_cyc = -1;
      int n_done = 0;
      load_basic_program();
      for (int cyc = 0; cyc < 20; cyc++) begin
         @(negedge clk);
         go = (cyc == 0); n_instr = 4'd3; opnd_valid = 1'b1;
         #1;
         if (cyc == 1) begin
            n_checks++; if (busy !== 1'b1 || ir_load !== 1'b1) begin
               n_fail++; $display("FAIL basic_c1: busy=%b ir_load=%b want 1 1", busy, ir_load);
            end
         end
         if (mem_we) begin
            if (wi < 3) begin
               n_checks++; if (cyc !== exp_cyc[wi]) begin n_fail++; $display("FAIL basic_we_cyc%0d: got %0d want %0d", wi, cyc, exp_cyc[wi]); end
               n_checks++; if (w_addr !== 4'(exp_wa[wi])) begin n_fail++; $display("FAIL basic_w_addr%0d: got %0d want %0d", wi, w_addr, exp_wa[wi]); end
               n_checks++; if (alu_op !== 2'(exp_op[wi])) begin n_fail++; $display("FAIL basic_alu_op%0d: got %0d want %0d", wi, alu_op, exp_op[wi]); end
            end
            wi++;
         end
         if (done) begin done_cyc = cyc; n_done++; end
      end
      go = 1'b0;
      n_checks++; if (wi !== 3) begin n_fail++; $display("FAIL basic_nwrites: got %0d want 3", wi); end
      n_checks++; if (done_cyc !== 13 || n_done !== 1) begin n_fail++; $display("FAIL basic_done: cyc %0d count %0d want 13 1", done_cyc, n_done); end
      n_checks++; if (wr_count !== 4'd3) begin n_fail++; $display("FAIL basic_wr_count: got %0d want 3", wr_count); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_end: got %b want 0", busy); end
   endtask

   task automatic test_operand_stall();
      int first_we = -1;
      int wi = 0;
      int done_cyc = -1;
      load_basic_program();
      for (int cyc = 0; cyc < 22; cyc++) begin
         @(negedge clk);
         go = (cyc == 0); n_instr = 4'd3; opnd_valid = !(cyc >= 2 && cyc <= 6);
         #1;
         if (cyc >= 2 && cyc <= 6) begin
            n_checks++; if (opnd_ready !== 1'b1 || a_load !== 1'b0 || b_load !== 1'b0) begin
               n_fail++; $display("FAIL stall_c%0d: ready=%b a=%b b=%b want 1 0 0", cyc, opnd_ready, a_load, b_load);
            end
         end
         if (cyc == 7) begin
            n_checks++; if (a_load !== 1'b1 || b_load !== 1'b1) begin
               n_fail++; $display("FAIL stall_load: a=%b b=%b want 1 1", a_load, b_load);
            end
         end
         if (mem_we) begin if (first_we < 0) first_we = cyc; wi++; end
         if (done) done_cyc = cyc;
      end
      go = 1'b0;
      n_checks++; if (first_we !== 9) begin n_fail++; $display("FAIL stall_first_we: got %0d want 9", first_we); end
      n_checks++; if (wi !== 3 || done_cyc !== 18) begin n_fail++; $display("FAIL stall_end: writes %0d done %0d want 3 18", wi, done_cyc); end
   endtask

   task automatic test_zero_count();
      int n_ir = 0;
      int n_we = 0;
      int done_cyc = -1;
      for (int cyc = 0; cyc < 6; cyc++) begin
         @(negedge clk);
         go = (cyc == 0); n_instr = 4'd0; opnd_valid = 1'b1;
         #1;
         if (ir_load) n_ir++;
         if (mem_we) n_we++;
         if (done) done_cyc = cyc;
      end
      go = 1'b0;
      n_checks++; if (done_cyc !== 1) begin n_fail++; $display("FAIL zero_done: cyc %0d want 1", done_cyc); end
      n_checks++; if (n_ir !== 0 || n_we !== 0) begin n_fail++; $display("FAIL zero_strobes: ir %0d we %0d want 0 0", n_ir, n_we); end
      n_checks++; if (wr_count !== 4'd0) begin n_fail++; $display("FAIL zero_wr_count: got %0d want 0", wr_count); end
   endtask

   task automatic test_clamp();
      int n_we = 0;
      int max_ra = 0;
      int done_cyc = -1;
      for (int i = 0; i < 8; i++) mem[i] = 5'(i * 4 + 1);
      for (int cyc = 0; cyc < 40; cyc++) begin
         @(negedge clk);
         go = (cyc == 0); n_instr = 4'd12; opnd_valid = 1'b1;
         #1;
         if (int'(r_addr) > max_ra) max_ra = int'(r_addr);
         if (mem_we) n_we++;
         if (done) done_cyc = cyc;
      end
      go = 1'b0;
      n_checks++; if (n_we !== 8) begin n_fail++; $display("FAIL clamp_writes: got %0d want 8", n_we); end
      n_checks++; if (max_ra !== 7) begin n_fail++; $display("FAIL clamp_r_addr: max %0d want 7", max_ra); end
      n_checks++; if (done_cyc !== 33 || wr_count !== 4'd8) begin n_fail++; $display("FAIL clamp_end: done %0d wr_count %0d want 33 8", done_cyc, wr_count); end
   endtask

   task automatic test_go_ignored();
      int n_we = 0;
      int done_cyc = -1;
      int busy_late = 0;
      load_basic_program();
      for (int cyc = 0; cyc < 15; cyc++) begin
         @(negedge clk);
         go = (cyc == 0 || cyc == 3 || cyc == 6 || cyc == 9);
         n_instr = (cyc == 0) ? 4'd2 : 4'd5;
         opnd_valid = 1'b1;
         #1;
         if (mem_we) n_we++;
         if (done) done_cyc = cyc;
         if (cyc >= 10 && busy) busy_late++;
      end
      go = 1'b0;
      n_checks++; if (n_we !== 2 || done_cyc !== 9) begin n_fail++; $display("FAIL goign_run: writes %0d done %0d want 2 9", n_we, done_cyc); end
      n_checks++; if (busy_late !== 0) begin n_fail++; $display("FAIL goign_restart: busy cycles %0d want 0", busy_late); end
      n_checks++; if (wr_count !== 4'd2) begin n_fail++; $display("FAIL goign_wr_count: got %0d want 2", wr_count); end
   endtask

   task automatic test_reset_mid_run();
      int late_we = 0;
      int first_we = -1;
      logic [3:0] first_wa = 4'd0;
      load_basic_program();
      for (int cyc = 0; cyc < 14; cyc++) begin
         @(negedge clk);
         go = (cyc == 0); n_instr = 4'd3; opnd_valid = 1'b1; rst = (cyc == 6);
         #1;
         if (cyc == 6) begin
            n_checks++; if (opnd_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_in_opnd: ready %b want 1", opnd_ready); end
         end
         if (cyc == 7) begin
            n_checks++;
            if ({busy, ir_load, opnd_ready, a_load, mem_we, done} !== 6'b0 || r_addr !== 4'd0 ||
                wr_count !== 4'd0 || alu_op !== 2'd0 || w_addr !== 4'd8) begin
               n_fail++;
               $display("FAIL midrst_state: strobes %b r_addr %0d wr_count %0d op %0d w_addr %0d",
                        {busy, ir_load, opnd_ready, a_load, mem_we, done}, r_addr, wr_count,
                        alu_op, w_addr);
            end
         end
         if (cyc >= 7 && mem_we) late_we++;
      end
      n_checks++; if (late_we !== 0) begin n_fail++; $display("FAIL midrst_we_after: got %0d want 0", late_we); end
      for (int cyc = 0; cyc < 16; cyc++) begin
         @(negedge clk);
         go = (cyc == 0); n_instr = 4'd3; opnd_valid = 1'b1; rst = 1'b0;
         #1;
         if (mem_we && first_we < 0) begin first_we = cyc; first_wa = w_addr; end
      end
      go = 1'b0;
      n_checks++; if (first_we !== 4 || first_wa !== 4'd9) begin n_fail++; $display("FAIL midrst_rerun: we cyc %0d w_addr %0d want 4 9", first_we, first_wa); end
   endtask

   task automatic test_dup_dest();
      int wi = 0;
      int wa[2] = '{0, 0};
      int op[2] = '{0, 0};
      for (int i = 0; i < 16; i++) mem[i] = 5'b00000;
      mem[0] = 5'b01000;
      mem[1] = 5'b01010;
      for (int cyc = 0; cyc < 12; cyc++) begin
         @(negedge clk);
         go = (cyc == 0); n_instr = 4'd2; opnd_valid = 1'b1;
         #1;
         if (mem_we) begin
            if (wi < 2) begin wa[wi] = int'(w_addr); op[wi] = int'(alu_op); end
            wi++;
         end
      end
      go = 1'b0;
      n_checks++; if (wi !== 2 || wa[0] !== 10 || wa[1] !== 10) begin n_fail++; $display("FAIL dup_addr: writes %0d addr %0d %0d want 2 10 10", wi, wa[0], wa[1]); end
      n_checks++; if (op[0] !== 0 || op[1] !== 2) begin n_fail++; $display("FAIL dup_op: got %0d %0d want 0 2", op[0], op[1]); end
      n_checks++; if (wr_count !== 4'd2) begin n_fail++; $display("FAIL dup_wr_count: got %0d want 2", wr_count); end
   endtask

   initial begin
      rst = 1'b1; go = 1'b0; n_instr = 4'd0; opnd_valid = 1'b0;
      load_basic_program();
      test_reset();
      test_basic_program();
      test_operand_stall();
      test_zero_count();
      test_clamp();
      test_go_ignored();
      test_reset_mid_run();
      test_dup_dest();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
